// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: P = X * Y, one partial-product
// step per clock, WIDTH steps per multiply, with busy/done handshake.
module shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     X,
  input  logic [WIDTH-1:0]     Y,
  output logic [2*WIDTH-1:0]   P,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [WIDTH:0]       sum_s;
  logic                 carry_s;
  logic                 accept_s;
  logic                 last_step_s;

  assign accept_s    = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_step_s = (state_q == RUN) && (count_q == CW'(1));

  // State and datapath registers; reset discards any in-flight multiply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      count_q <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      count_q <= count_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; DONE may relaunch directly for back-to-back operation.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
        else       state_d = IDLE;
      end
      RUN: begin
        if (count_q == CW'(1)) state_d = DONE;
        else                   state_d = RUN;
      end
      DONE: begin
        if (start) state_d = RUN;
        else       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // One step: conditional add into {C,A}, then shift {C,A,Q} right with a 0 fill.
  always_comb begin
    sum_s   = {1'b0, a_q} + (q_q[0] ? {1'b0, m_q} : {(WIDTH + 1){1'b0}});
    carry_s = sum_s[WIDTH];
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    count_d = count_q;
    if (accept_s) begin
      m_d     = X;
      q_d     = Y;
      a_d     = '0;
      count_d = CW'(WIDTH);
    end else if (state_q == RUN) begin
      a_d     = {carry_s, sum_s[WIDTH-1:1]};
      q_d     = {sum_s[0], q_q[WIDTH-1:1]};
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Registered outputs; P only loads on the final step so no partial product leaks.
  always_comb begin
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
    if (last_step_s) p_d = {a_d, q_d};
    else             p_d = p_q;
  end

  assign P    = p_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: WIDTH=4 and WIDTH=8 instances.
module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start4, start8;
  logic [3:0]  x4, y4;
  logic [7:0]  x8, y8;
  logic [7:0]  p4;
  logic [15:0] p8;
  logic        busy4, done4, busy8, done8;

  logic [15:0] exp4_q[$];
  logic [15:0] exp8_q[$];
  logic [15:0] e4, e8;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  shift_add_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .X(x4), .Y(y4),
    .P(p4), .busy(busy4), .done(done4)
  );

  shift_add_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .X(x8), .Y(y8),
    .P(p8), .busy(busy8), .done(done8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard for the 4-bit instance: every done pulse must match a queued product.
  always @(negedge clk) begin
    if (rst_n && done4) begin
      check("busy_with_done4", {31'd0, busy4}, 32'd0);
      if (exp4_q.size() == 0) check("unexpected_done4", 32'd1, 32'd0);
      else begin
        e4 = exp4_q.pop_front();
        check("p4", {24'd0, p4}, {16'd0, e4});
      end
    end
  end

  // Scoreboard for the 8-bit instance.
  always @(negedge clk) begin
    if (rst_n && done8) begin
      check("busy_with_done8", {31'd0, busy8}, 32'd0);
      if (exp8_q.size() == 0) check("unexpected_done8", 32'd1, 32'd0);
      else begin
        e8 = exp8_q.pop_front();
        check("p8", {16'd0, p8}, {16'd0, e8});
      end
    end
  end

  task automatic wait_done(input bit w8, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(w8 ? done8 : done4) && cyc < 40);
  endtask

  task automatic run_mul(input bit w8, input logic [7:0] x, input logic [7:0] y);
    int          cyc;
    logic [15:0] prod;
    logic [15:0] pv;
    prod = 16'(x) * 16'(y);
    @(negedge clk);
    if (w8) begin
      x8 = x; y8 = y; start8 = 1'b1; exp8_q.push_back(prod);
    end else begin
      x4 = x[3:0]; y4 = y[3:0]; start4 = 1'b1; exp4_q.push_back(prod);
    end
    @(negedge clk);
    start4 = 1'b0; start8 = 1'b0;
    x4 = 4'd0; y4 = 4'd0; x8 = 8'd0; y8 = 8'd0;
    check("busy_after_accept", {31'd0, (w8 ? busy8 : busy4)}, 32'd1);
    wait_done(w8, cyc);
    check("latency", 32'(cyc), (w8 ? 32'd8 : 32'd4));
    @(negedge clk);
    pv = w8 ? p8 : {8'd0, p4};
    check("done_cleared", {31'd0, (w8 ? done8 : done4)}, 32'd0);
    check("busy_cleared", {31'd0, (w8 ? busy8 : busy4)}, 32'd0);
    check("p_holds", {16'd0, pv}, {16'd0, prod});
    if (y != 8'd0) begin
      check("div_quotient", {16'd0, pv / 16'(y)}, {24'd0, x});
      check("div_remainder", {16'd0, pv % 16'(y)}, 32'd0);
    end
  endtask

  initial begin
    int cyc;
    logic [7:0] xs [8] = '{8'd12, 8'd13, 8'd5, 8'd9, 8'd14, 8'd15, 8'd0, 8'd13};
    logic [7:0] ys [8] = '{8'd3, 8'd12, 8'd10, 8'd12, 8'd9, 8'd15, 8'd13, 8'd0};

    rst_n = 1'b0;
    start4 = 1'b0; start8 = 1'b0;
    x4 = 4'd0; y4 = 4'd0; x8 = 8'd0; y8 = 8'd0;
    repeat (2) @(negedge clk);
    check("reset_p", {24'd0, p4}, 32'd0);
    check("reset_busy", {31'd0, busy4}, 32'd0);
    check("reset_done", {31'd0, done4}, 32'd0);
    rst_n = 1'b1;

    run_mul(1'b0, 8'd6, 8'd2);
    for (int i = 0; i < 8; i++) run_mul(1'b0, xs[i], ys[i]);

    // Start held through RUN is ignored; held into DONE it relaunches.
    @(negedge clk);
    x4 = 4'd10; y4 = 4'd10; start4 = 1'b1;
    exp4_q.push_back(16'd100);
    exp4_q.push_back(16'd9);
    @(negedge clk);
    x4 = 4'd3; y4 = 4'd3;
    wait_done(1'b0, cyc);
    check("b2b_latency1", 32'(cyc), 32'd4);
    @(negedge clk);
    start4 = 1'b0;
    check("b2b_relaunch_busy", {31'd0, busy4}, 32'd1);
    wait_done(1'b0, cyc);
    check("b2b_latency2", 32'(cyc), 32'd4);
    @(negedge clk);
    check("b2b_p_holds", {24'd0, p4}, 32'd9);

    // Asynchronous reset mid-operation discards the result.
    @(negedge clk);
    x4 = 4'd15; y4 = 4'd15; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_p", {24'd0, p4}, 32'd0);
    check("async_rst_busy", {31'd0, busy4}, 32'd0);
    check("async_rst_done", {31'd0, done4}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("no_done_after_rst", {31'd0, done4}, 32'd0);
    run_mul(1'b0, 8'd7, 8'd7);

    run_mul(1'b1, 8'd255, 8'd255);
    run_mul(1'b1, 8'd200, 8'd3);

    check("queue4_drained", 32'(exp4_q.size()), 32'd0);
    check("queue8_drained", 32'(exp8_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
